// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults and sprite record for vga_sprite_timing.
//   Default 640x480 timing values, derived line/frame totals and active-area
//   start positions, counter/coordinate widths and the sprite_t record used
//   for both the shadow (writer-facing) and live (display-facing) banks.
package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_PULSE_D  = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_PULSE_D  = 2;
  localparam int V_BP_D     = 29;

  localparam int HT_D      = H_PULSE_D + H_BP_D + H_ACTIVE_D + H_FP_D;
  localparam int VT_D      = V_PULSE_D + V_BP_D + V_ACTIVE_D + V_FP_D;
  localparam int H_START_D = H_PULSE_D + H_BP_D;
  localparam int V_START_D = V_PULSE_D + V_BP_D;

  // Counters and sprite compares share an 11-bit datapath so that
  // centre+HALF never overflows and px+HALF never goes negative.
  localparam int CNT_W     = 11;
  localparam int COORD_W   = 10;
  // Colour field is sized for up to 8 bits per channel; the top level
  // uses the low 3*CW bits.
  localparam int RGB_MAX_W = 24;

  typedef struct packed {
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic                 en;
    logic [RGB_MAX_W-1:0] rgb;
  } sprite_t;

endpackage

// File: rtl/vga_sprite_hit.sv
// vga_sprite_hit: combinational box test for one square sprite.
//   px_i, py_i : active-area pixel coordinate (CNT_W bits)
//   spr_i      : live sprite record (centre x/y, enable, colour)
//   hit_o      : pixel lies inside the enabled 2*HALF square box
module vga_sprite_hit
  import vga_pkg::*;
#(
  parameter int HALF = 20
) (
  input  logic [CNT_W-1:0] px_i,
  input  logic [CNT_W-1:0] py_i,
  input  sprite_t          spr_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] half_w;
  logic [CNT_W-1:0] x_w;
  logic [CNT_W-1:0] y_w;
  logic             unused_rgb;

  assign half_w = CNT_W'(HALF);
  assign x_w    = CNT_W'(spr_i.x);
  assign y_w    = CNT_W'(spr_i.y);

  // Lower bound written as px+HALF >= x instead of px >= x-HALF so a
  // centre near 0 cannot wrap around.
  assign hit_o = spr_i.en
              && (px_i + half_w >= x_w) && (px_i < x_w + half_w)
              && (py_i + half_w >= y_w) && (py_i < y_w + half_w);

  assign unused_rgb = ^spr_i.rgb;

endmodule

// File: rtl/vga_sprite_timing.sv
// vga_sprite_timing: VGA timing generator with NSPR solid square sprites.
//   dclk, clr_n             : pixel clock, async active-low reset
//   pos_valid/pos_ready     : sprite write handshake into shadow bank
//   pos_id/x/y/en/rgb       : sprite write payload
//   hsync, vsync            : registered active-low syncs
//   red, green, blue        : registered pixel colour
//   frame_start             : one-cycle pulse on the first output cycle of a frame
// Shadow registers are copied to live registers on the last cycle of the
// frame so a frame is never drawn with a half-updated sprite set.
module vga_sprite_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_PULSE  = H_PULSE_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_PULSE  = V_PULSE_D,
  parameter int V_BP     = V_BP_D,
  parameter int NSPR     = 4,
  parameter int HALF     = 20,
  parameter int CW       = 3,
  parameter logic [3*CW-1:0] BG_RGB = '1,
  localparam int IDW     = (NSPR > 1) ? $clog2(NSPR) : 1
) (
  input  logic               dclk,
  input  logic               clr_n,
  input  logic               pos_valid,
  output logic               pos_ready,
  input  logic [IDW-1:0]     pos_id,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               pos_en,
  input  logic [3*CW-1:0]    pos_rgb,
  output logic               hsync,
  output logic               vsync,
  output logic [CW-1:0]      red,
  output logic [CW-1:0]      green,
  output logic [CW-1:0]      blue,
  output logic               frame_start
);

  localparam int HT      = H_PULSE + H_BP + H_ACTIVE + H_FP;
  localparam int VT      = V_PULSE + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_PULSE + H_BP;
  localparam int V_START = V_PULSE + V_BP;

  localparam logic [CNT_W-1:0] HT_M1     = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] VT_M1     = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_PULSE_C = CNT_W'(H_PULSE);
  localparam logic [CNT_W-1:0] V_PULSE_C = CNT_W'(V_PULSE);
  localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_START + V_ACTIVE);

  logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
  logic             commit, wr_fire;
  sprite_t          shadow_q [NSPR];
  sprite_t          shadow_d [NSPR];
  sprite_t          live_q   [NSPR];
  sprite_t          live_d   [NSPR];
  logic             rdy_q, rdy_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;
  logic [3*CW-1:0]  rgb_q, rgb_d;
  logic             active;
  logic [CNT_W-1:0] px, py;
  logic [NSPR-1:0]  hit;

  assign commit  = (hc_q == HT_M1) && (vc_q == VT_M1);
  assign wr_fire = pos_valid && rdy_q;

  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_q == HT_M1) begin
      hc_d = '0;
      vc_d = (vc_q == VT_M1) ? '0 : vc_q + 1'b1;
    end
    // Ready is registered from the next count, so it drops exactly for the
    // commit cycle and stays low during (and the cycle after) reset.
    rdy_d = !((hc_d == HT_M1) && (vc_d == VT_M1));
  end

  always_comb begin
    shadow_d = shadow_q;
    live_d   = live_q;
    if (commit) live_d = shadow_q;
    for (int i = 0; i < NSPR; i++) begin
      if (wr_fire && (pos_id == IDW'(i))) begin
        shadow_d[i].x   = pos_x;
        shadow_d[i].y   = pos_y;
        shadow_d[i].en  = pos_en;
        shadow_d[i].rgb = RGB_MAX_W'(pos_rgb);
      end
    end
  end

  assign active = (hc_q >= H_START_C) && (hc_q < H_END_C)
               && (vc_q >= V_START_C) && (vc_q < V_END_C);
  assign px = hc_q - H_START_C;
  assign py = vc_q - V_START_C;

  for (genvar g = 0; g < NSPR; g++) begin : g_hit
    vga_sprite_hit #(.HALF(HALF)) u_hit (
      .px_i  (px),
      .py_i  (py),
      .spr_i (live_q[g]),
      .hit_o (hit[g])
    );
  end

  always_comb begin
    rgb_d = BG_RGB;
    // Walk from the highest id down so the lowest hitting id wins.
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (hit[i]) rgb_d = live_q[i].rgb[3*CW-1:0];
    end
    if (!active) rgb_d = '0;
    hsync_d = (hc_q >= H_PULSE_C);
    vsync_d = (vc_q >= V_PULSE_C);
    fs_d    = (hc_q == '0) && (vc_q == '0);
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      hc_q    <= '0;
      vc_q    <= '0;
      rdy_q   <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
      for (int i = 0; i < NSPR; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
    end else begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      rdy_q    <= rdy_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fs_q     <= fs_d;
      rgb_q    <= rgb_d;
      shadow_q <= shadow_d;
      live_q   <= live_d;
    end
  end

  assign pos_ready   = rdy_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
  assign red         = rgb_q[3*CW-1:2*CW];
  assign green       = rgb_q[2*CW-1:CW];
  assign blue        = rgb_q[CW-1:0];

endmodule
